// File: rtl/prng_pkg.sv
// Shared definitions for the bounded PRNG: LFSR tap table, draw FSM states and
// the rejection mask helper.
package prng_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } draw_state_e;

    // Fibonacci feedback taps (bit positions, LSB = 0) giving a maximal-length sequence.
    function automatic logic [31:0] tap_mask(input int unsigned width);
        logic [31:0] t;
        case (width)
            4:       t = 32'h0000_000C;
            5:       t = 32'h0000_0014;
            6:       t = 32'h0000_0030;
            7:       t = 32'h0000_0060;
            8:       t = 32'h0000_00B8;
            9:       t = 32'h0000_0110;
            10:      t = 32'h0000_0240;
            11:      t = 32'h0000_0500;
            12:      t = 32'h0000_0829;
            13:      t = 32'h0000_100D;
            14:      t = 32'h0000_2015;
            15:      t = 32'h0000_6000;
            16:      t = 32'h0000_D008;
            17:      t = 32'h0001_2000;
            18:      t = 32'h0002_0400;
            19:      t = 32'h0004_0023;
            20:      t = 32'h0009_0000;
            21:      t = 32'h0014_0000;
            22:      t = 32'h0030_0000;
            23:      t = 32'h0042_0000;
            24:      t = 32'h00E1_0000;
            25:      t = 32'h0120_0000;
            26:      t = 32'h0200_0023;
            27:      t = 32'h0400_0013;
            28:      t = 32'h0900_0000;
            29:      t = 32'h1400_0000;
            30:      t = 32'h2000_0029;
            31:      t = 32'h4800_0000;
            32:      t = 32'h8020_0003;
            default: t = 32'h0000_0000;
        endcase
        return t;
    endfunction

    // Smallest 2^k-1 covering lim-1; a zero limit means the full range.
    function automatic logic [31:0] limit_mask(input logic [31:0] lim);
        logic [31:0] m;
        if (lim == 32'd0) begin
            return '1;
        end
        m = '0;
        for (int i = 0; i < 32; i++) begin
            if (m < lim - 32'd1) begin
                m = {m[30:0], 1'b1};
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/prng_gen_lfsr_core.sv
// LFSR state register with seed load (zero seed replaced by 1) and one-step advance.
module lfsr_core
    import prng_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             f_crystal,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             step,
    output logic [WIDTH-1:0] num,
    output logic [WIDTH-1:0] num_step
);

    localparam logic [WIDTH-1:0] Taps = WIDTH'(tap_mask(WIDTH));

    logic [WIDTH-1:0] num_q;

    assign num_step = {num_q[WIDTH-2:0], ^(num_q & Taps)};
    assign num      = num_q;

    always_ff @(posedge f_crystal or negedge rst) begin
        if (!rst) begin
            num_q <= WIDTH'(1);
        end else if (load) begin
            num_q <= (seed == '0) ? WIDTH'(1) : seed;
        end else if (step) begin
            num_q <= num_step;
        end
    end

endmodule

// File: rtl/prng_gen.sv
// LFSR random source with free-run / single-step control and a rejection-sampling
// engine that produces values below a requested limit.
module prng_gen
    import prng_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned OUT_W   = 8,
    parameter int unsigned MAX_TRY = 16
) (
    input  logic             f_crystal,
    input  logic             rst,
    input  logic             run,
    input  logic             next,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    input  logic             draw_req,
    input  logic [OUT_W-1:0] draw_limit,
    input  logic             draw_ack,
    output logic [WIDTH-1:0] num,
    output logic [OUT_W-1:0] draw_val,
    output logic             draw_valid,
    output logic             draw_busy
);

    draw_state_e      state_q, state_d;
    logic [OUT_W-1:0] lim_q, lim_d;
    logic [OUT_W-1:0] val_q, val_d;
    logic [7:0]       try_q, try_d;
    logic             last_next_q;
    logic             lfsr_step;
    logic             accept;
    logic [OUT_W-1:0] mask;
    logic [OUT_W-1:0] cand;
    logic [WIDTH-1:0] num_step;

    lfsr_core #(
        .WIDTH(WIDTH)
    ) u_lfsr_core (
        .f_crystal(f_crystal),
        .rst      (rst),
        .load     (seed_load),
        .seed     (seed),
        .step     (lfsr_step),
        .num      (num),
        .num_step (num_step)
    );

    // Candidate is taken from the state the LFSR moves to on this edge.
    assign mask   = OUT_W'(limit_mask(32'(lim_q)));
    assign cand   = OUT_W'(num_step) & mask;
    assign accept = (lim_q == '0) || (cand < lim_q);

    always_comb begin
        state_d   = state_q;
        lim_d     = lim_q;
        val_d     = val_q;
        try_d     = try_q;
        lfsr_step = 1'b0;

        if (seed_load) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (draw_req) begin
                        state_d = StShift;
                        lim_d   = draw_limit;
                        try_d   = '0;
                    end
                end
                StShift: begin
                    lfsr_step = 1'b1;
                    if (accept) begin
                        val_d   = cand;
                        state_d = StDone;
                    end else if (try_q == 8'(MAX_TRY - 1)) begin
                        // Rejected candidates never exceed 2*lim-2, so this stays below lim.
                        val_d   = cand - lim_q;
                        state_d = StDone;
                    end else begin
                        try_d = try_q + 8'd1;
                    end
                end
                StDone: begin
                    if (draw_ack) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase

            if (state_q != StShift && (run || (next && !last_next_q))) begin
                lfsr_step = 1'b1;
            end
        end
    end

    always_ff @(posedge f_crystal or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            lim_q       <= '0;
            val_q       <= '0;
            try_q       <= '0;
            last_next_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lim_q       <= lim_d;
            val_q       <= val_d;
            try_q       <= try_d;
            last_next_q <= next;
        end
    end

    assign draw_val   = val_q;
    assign draw_valid = (state_q == StDone);
    assign draw_busy  = (state_q != StIdle);

endmodule

// File: tb/tb_prng_gen.sv
// Randomized scoreboard bench for prng_gen against a behavioural LFSR/draw model.
module tb_prng_gen;

    localparam int W  = 16;
    localparam int OW = 8;
    localparam int MT = 16;

    logic          f_crystal = 1'b0;
    logic          rst = 1'b1;
    logic          run = 1'b0;
    logic          next = 1'b0;
    logic          seed_load = 1'b0;
    logic [W-1:0]  seed = '0;
    logic          draw_req = 1'b0;
    logic [OW-1:0] draw_limit = '0;
    logic          draw_ack = 1'b0;
    logic [W-1:0]  num;
    logic [OW-1:0] draw_val;
    logic          draw_valid;
    logic          draw_busy;

    prng_gen #(
        .WIDTH  (W),
        .OUT_W  (OW),
        .MAX_TRY(MT)
    ) dut (
        .f_crystal (f_crystal),
        .rst       (rst),
        .run       (run),
        .next      (next),
        .seed_load (seed_load),
        .seed      (seed),
        .draw_req  (draw_req),
        .draw_limit(draw_limit),
        .draw_ack  (draw_ack),
        .num       (num),
        .draw_val  (draw_val),
        .draw_valid(draw_valid),
        .draw_busy (draw_busy)
    );

    always #5 f_crystal = ~f_crystal;

    typedef struct {
        int unsigned val;
        int unsigned lat;
        int unsigned req_edge;
        int unsigned lim;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;

    always @(posedge f_crystal) cyc <= cyc + 1;

    // Reference model state
    logic [W-1:0] m_num = 16'h0001;
    bit           m_last = 1'b0;
    int           m_phase = 0;  // 0 idle, 1 drawing, 2 result held
    int           m_left = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] s);
        return {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]};
    endfunction

    // Walk the LFSR forward from the current state to find the bounded result.
    task automatic plan_draw(input logic [OW-1:0] lim);
        logic [W-1:0] s;
        int unsigned  mask, cand, val, tries, l;
        exp_t         e;
        s = m_num;
        l = int'(lim);
        mask = (l == 0) ? 255 : ((1 << $clog2(l)) - 1);
        val = 0;
        tries = MT;
        for (int k = 1; k <= MT; k++) begin
            s = lfsr_next(s);
            cand = int'(s[7:0]) & mask;
            if (l == 0 || cand < l) begin
                val = cand;
                tries = k;
                break;
            end
            if (k == MT) val = cand - l;
        end
        e.val = val;
        e.lat = tries + 1;
        e.req_edge = cyc + 1;
        e.lim = l;
        sb.push_back(e);
        m_phase = 1;
        m_left = tries;
    endtask

    task automatic drive(input bit sl, input logic [W-1:0] sd, input bit r, input bit nx,
                         input bit rq, input logic [OW-1:0] lim, input bit ack);
        int p;
        p = m_phase;
        seed_load = sl;
        seed = sd;
        run = r;
        next = nx;
        draw_req = rq;
        draw_limit = lim;
        draw_ack = ack;
        if (sl) begin
            if (p == 1) sb.delete(sb.size() - 1);
            m_num = (sd == '0) ? 16'h0001 : sd;
            m_phase = 0;
        end else begin
            if (p == 1) begin
                m_num = lfsr_next(m_num);
                m_left--;
                if (m_left == 0) m_phase = 2;
            end else if (r || (nx && !m_last)) begin
                m_num = lfsr_next(m_num);
            end
            if (p == 0 && rq) plan_draw(lim);
            if (p == 2 && ack) m_phase = 0;
        end
        m_last = nx;
        @(posedge f_crystal);
        #1;
        check("num", num, m_num);
        check("busy", draw_busy, m_phase != 0);
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic reset_now();
        #2;
        rst = 1'b0;
        if (m_phase == 1) sb.delete(sb.size() - 1);
        m_num = 16'h0001;
        m_phase = 0;
        m_last = 1'b0;
        {seed_load, run, next, draw_req, draw_ack} = '0;
        #1;
        check("rst_num", num, 16'h0001);
        check("rst_valid", draw_valid, 1'b0);
        check("rst_busy", draw_busy, 1'b0);
        check("rst_val", draw_val, 8'h00);
        @(posedge f_crystal);
        #1;
        rst = 1'b1;
    endtask

    // Monitor: pops the scoreboard whenever a new result is presented.
    bit          mon_prev = 1'b0;
    bit          mon_have = 1'b0;
    int unsigned mon_held = 0;
    exp_t        mon_e;

    initial begin
        forever begin
            @(negedge f_crystal);
            if (draw_valid === 1'b1) begin
                if (!mon_prev) begin
                    if (sb.size() == 0) begin
                        check("unexpected_valid", draw_valid, 1'b0);
                        mon_have = 1'b0;
                    end else begin
                        mon_e = sb.pop_front();
                        mon_held = mon_e.val;
                        mon_have = 1'b1;
                        check("draw_val", draw_val, mon_e.val);
                        check("latency", cyc - mon_e.req_edge + 1, mon_e.lat);
                        check("val_range", (mon_e.lim == 0) || (int'(draw_val) < mon_e.lim), 1'b1);
                    end
                end else if (mon_have) begin
                    check("val_stable", draw_val, mon_held);
                end
                mon_prev = 1'b1;
            end else begin
                mon_prev = 1'b0;
                mon_have = 1'b0;
            end
        end
    end

    initial begin
        logic [W-1:0] exp036[4];
        int           first_ret;
        bit           zero_seen;
        int           guard;
        logic [OW-1:0] lim;

        exp036 = '{16'h0002, 16'h0004, 16'h0008, 16'h0011};

        // Reset with run held high: no step until after release.
        #1;
        rst = 1'b0;
        run = 1'b1;
        @(posedge f_crystal);
        @(posedge f_crystal);
        #1;
        check("init_num", num, 16'h0001);
        check("init_valid", draw_valid, 1'b0);
        check("init_busy", draw_busy, 1'b0);
        check("init_val", draw_val, 8'h00);
        rst = 1'b1;
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        check("first_step", num, 16'h0002);

        // Single-step edges from reset.
        reset_now();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
            check("next_edge", num, exp036[i]);
            drive(1'b0, '0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
            check("next_held", num, exp036[i]);
            idle();
        end

        // Seed loading.
        drive(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        check("seed_zero", num, 16'h0001);
        drive(1'b1, 16'hACE1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        check("seed_over_run", num, 16'hACE1);

        // Full period from seed 1.
        drive(1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        first_ret = 0;
        zero_seen = 1'b0;
        for (int i = 1; i <= 65535; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
            if (num == 16'h0001 && first_ret == 0) first_ret = i;
            if (num == 16'h0000) zero_seen = 1'b1;
        end
        check("period", first_ret, 65535);
        check("never_zero", zero_seen, 1'b0);

        // Limit 1 and limit 0 both accept on the first try.
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 8'd1, 1'b0);
        idle();
        check("lim1_valid", draw_valid, 1'b1);
        check("lim1_val", draw_val, 8'h00);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0);
        idle();
        check("lim0_valid", draw_valid, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1);

        // Abort by seed load during the draw.
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 8'd10, 1'b0);
        drive(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        check("abort_seed_valid", draw_valid, 1'b0);
        check("abort_seed_num", num, 16'h1234);
        repeat (20) idle();

        // Abort by reset during the draw.
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 8'd10, 1'b0);
        reset_now();
        repeat (20) idle();
        check("abort_rst_valid", draw_valid, 1'b0);

        // Randomized draws with free-run/step noise and spurious requests.
        drive(1'b1, 16'(($urandom & 16'hFFFF)), 1'b0, 1'b0, 1'b0, '0, 1'b0);
        for (int d = 0; d < 1000; d++) begin
            lim = (d % 4 == 3) ? 8'($urandom_range(0, 255)) : 8'd10;
            drive(1'b0, '0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, lim, 1'b0);
            guard = 0;
            while (m_phase == 1 && guard < 40) begin
                drive(1'b0, '0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b0);
                guard++;
            end
            repeat ($urandom_range(0, 3)) begin
                drive(1'b0, '0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b0);
            end
            drive(1'b0, '0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b1);
        end

        repeat (4) idle();
        check("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
